// File: rtl/mips_seq_pkg.sv
// mips_seq_pkg: shared constants for the MIPS R-type instruction sequencer.
// Holds the FSM state encoding, the opcode/funct values the core supports,
// the instruction field positions and a helper to recognise executable words.
package mips_seq_pkg;

  // Instruction field widths and positions (classic MIPS R-type layout)
  localparam int OPCODE_W   = 6;
  localparam int FUNCT_W    = 6;
  localparam int REG_W      = 5;
  localparam int OPCODE_LSB = 26;
  localparam int RD_LSB     = 11;
  localparam int FUNCT_LSB  = 0;
  localparam int INSTR_W    = 32;

  // Sequencer state encoding
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // R-type opcode and the funct codes mips_core implements
  localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [FUNCT_W-1:0]  F_ADD    = 6'h20;
  localparam logic [FUNCT_W-1:0]  F_ADDU   = 6'h21;
  localparam logic [FUNCT_W-1:0]  F_SUB    = 6'h22;
  localparam logic [FUNCT_W-1:0]  F_AND    = 6'h24;
  localparam logic [FUNCT_W-1:0]  F_OR     = 6'h25;
  localparam logic [FUNCT_W-1:0]  F_SLL    = 6'h00;
  localparam logic [FUNCT_W-1:0]  F_SRL    = 6'h02;
  localparam logic [FUNCT_W-1:0]  F_SRA    = 6'h03;
  localparam logic [FUNCT_W-1:0]  F_SLTU   = 6'h2B;

  // Supported funct codes packed into one vector; entry k lives at [k*FUNCT_W +: FUNCT_W]
  localparam int NUM_FUNCT = 9;
  localparam logic [NUM_FUNCT*FUNCT_W-1:0] SUPPORTED_FUNCTS = {
    F_SLTU, F_SRA, F_SRL, F_SLL, F_OR, F_AND, F_SUB, F_ADDU, F_ADD
  };

  // Field extraction helpers
  function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] w);
    return w[OPCODE_LSB +: OPCODE_W];
  endfunction

  function automatic logic [FUNCT_W-1:0] funct_of(input logic [INSTR_W-1:0] w);
    return w[FUNCT_LSB +: FUNCT_W];
  endfunction

  function automatic logic [REG_W-1:0] rd_of(input logic [INSTR_W-1:0] w);
    return w[RD_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/mips_seq_imem.sv
// mips_seq_imem: program memory for the sequencer.
// One write port and one synchronous read port; the registered read data is
// the instruction word driven to the core, so it is reset to zero and only
// updates when a read is requested.
module mips_seq_imem #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_reg;

  // Program load write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; holds its word until the next read so the core input stays stable
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (re) begin
      rdata_reg <= mem[raddr];
    end
  end

  assign rdata = rdata_reg;

endmodule

// File: rtl/mips_instr_sequencer.sv
// mips_instr_sequencer: clocked driver for the combinational R-type mips_core.
// Runs prog_len words from the internal memory, three cycles per word
// (FETCH / EXEC / WB), and emits a one-cycle register-file write per legal word.
// Optional feature: define MIPS_SEQ_CYCLE_CNT_EN to add the 32-bit cycle_cnt
// output, which counts busy cycles of the most recent run.
module mips_instr_sequencer
  import mips_seq_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int ADDR_W     = 6,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [DATA_W-1:0] imem_wdata,
  input  logic [ADDR_W-1:0] prog_len,
  input  logic              start,
  output logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] result,
  output logic              wb_en,
  output logic [4:0]        wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done,
  output logic              illegal
`ifdef MIPS_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]       cycle_cnt
`endif
);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] len_reg;
  logic              wb_en_reg;
  logic [REG_W-1:0]  wb_addr_reg;
  logic [DATA_W-1:0] wb_data_reg;
  logic              illegal_reg;

  // FSM-decoded strobes
  logic              start_ok;
  logic              imem_re;
  logic              imem_wr;
  logic              exec_cap;
  logic              wb_step;
  logic              last_instr;

  // Decode of the word currently presented to the core
  logic [OPCODE_W-1:0]  cur_opcode;
  logic [FUNCT_W-1:0]   cur_funct;
  logic [REG_W-1:0]     cur_rd;
  logic [NUM_FUNCT-1:0] funct_hit;
  logic                 instr_legal;

  assign pc_inc     = pc_reg + 1'b1;
  assign last_instr = (pc_inc == len_reg);

  assign cur_opcode = opcode_of(instruction[INSTR_W-1:0]);
  assign cur_funct  = funct_of(instruction[INSTR_W-1:0]);
  assign cur_rd     = rd_of(instruction[INSTR_W-1:0]);

  // One comparator per supported funct code
  generate
    for (genvar gi = 0; gi < NUM_FUNCT; gi++) begin : g_funct_match
      assign funct_hit[gi] = (cur_funct == SUPPORTED_FUNCTS[gi*FUNCT_W +: FUNCT_W]);
    end
  endgenerate

  assign instr_legal = (cur_opcode == OP_RTYPE) && (|funct_hit);

  // Program memory; its registered read data is the instruction output
  mips_seq_imem #(
    .DEPTH  (IMEM_DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_imem (
    .clk   (clk),
    .reset (reset),
    .we    (imem_wr),
    .waddr (imem_waddr),
    .wdata (imem_wdata),
    .re    (imem_re),
    .raddr (pc_reg),
    .rdata (instruction)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: a zero-length run goes straight to DONE without fetching
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (prog_len != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: state_next = S_EXEC;
      S_EXEC:  state_next = S_WB;
      S_WB:    state_next = last_instr ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Moore outputs and per-state strobes
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    start_ok = 1'b0;
    imem_re  = 1'b0;
    imem_wr  = 1'b0;
    exec_cap = 1'b0;
    wb_step  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        start_ok = start;
        imem_wr  = imem_we;
      end
      S_FETCH: begin
        busy    = 1'b1;
        imem_re = 1'b1;
      end
      S_EXEC: begin
        busy     = 1'b1;
        exec_cap = 1'b1;
      end
      S_WB: begin
        busy    = 1'b1;
        wb_step = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Program counter and run length: rewound on start, advanced once per writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg  <= '0;
      len_reg <= '0;
    end else if (start_ok) begin
      pc_reg  <= '0;
      len_reg <= prog_len;
    end else if (wb_step) begin
      pc_reg  <= pc_inc;
    end
  end

  // Writeback: capture the core result in EXEC, pulse the write one cycle after WB
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_en_reg   <= 1'b0;
      wb_addr_reg <= '0;
      wb_data_reg <= '0;
    end else begin
      wb_en_reg <= wb_step && instr_legal && (cur_rd != '0);
      if (exec_cap) begin
        wb_data_reg <= result;
        wb_addr_reg <= cur_rd;
      end
    end
  end

  // Sticky illegal flag; writes to $zero are legal no-ops and never set it
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_reg <= 1'b0;
    end else if (start_ok) begin
      illegal_reg <= 1'b0;
    end else if (wb_step && !instr_legal) begin
      illegal_reg <= 1'b1;
    end
  end

  assign wb_en   = wb_en_reg;
  assign wb_addr = wb_addr_reg;
  assign wb_data = wb_data_reg;
  assign pc      = pc_reg;
  assign illegal = illegal_reg;

`ifdef MIPS_SEQ_CYCLE_CNT_EN
  logic [31:0] cycle_cnt_reg;

  // Busy-cycle counter for the latest run; frozen outside FETCH/EXEC/WB
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_reg <= '0;
    end else if (start_ok) begin
      cycle_cnt_reg <= '0;
    end else if (busy) begin
      cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_reg;
`endif

endmodule
